microwave_cook_ctrl: RTL and testbench

//  Top-level cook sequencer for the microwave. Takes keypad entry, start/stop keys and the door switch.

---
 rtl/microwave_pkg.sv | 22 ++
 rtl/bcd_mmss_down.sv | 62 ++++++
 rtl/microwave_cook_ctrl.sv | 132 +++++++++++++
 tb/tb_microwave_cook_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/microwave_pkg.sv
// rtl/microwave_pkg.sv - shared types and constants for the microwave cook controller
package microwave_pkg;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SET   = 3'd1,
      S_COOK  = 3'd2,
      S_PAUSE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t BCD_MAX_DIGIT  = 4'd9;
   localparam bcd_t BCD_MAX_TENS_S = 4'd5;

   // Seconds (0..59) to a {m10, m1, s10, s1} BCD word.
   function automatic logic [15:0] secs_to_mmss(input int unsigned secs);
      return {8'h00, 4'(secs / 10), 4'(secs % 10)};
   endfunction

endpackage

// File: rtl/bcd_mmss_down.sv
// rtl/bcd_mmss_down.sv - mm:ss BCD timer with keypad shift-in, load and borrowing countdown
module bcd_mmss_down
   import microwave_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic [15:0] load_val,
   input  logic        shift_en,
   input  bcd_t        shift_digit,
   input  logic        dec_en,
   input  logic        clr,
   output bcd_t        first_s,
   output bcd_t        second_s,
   output bcd_t        first_m,
   output bcd_t        second_m,
   output logic        zero
);

   assign zero = (first_s == 4'd0) && (second_s == 4'd0) &&
                 (first_m == 4'd0) && (second_m == 4'd0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         first_s  <= 4'd0;
         second_s <= 4'd0;
         first_m  <= 4'd0;
         second_m <= 4'd0;
      end else if (clr) begin
         first_s  <= 4'd0;
         second_s <= 4'd0;
         first_m  <= 4'd0;
         second_m <= 4'd0;
      end else if (load) begin
         {second_m, first_m, second_s, first_s} <= load_val;
      end else if (dec_en && !zero) begin
         // Tens of seconds only borrow to 5, so an entered 00:90 counts as 90 s.
         if (first_s != 4'd0) begin
            first_s <= first_s - 4'd1;
         end else begin
            first_s <= BCD_MAX_DIGIT;
            if (second_s != 4'd0) begin
               second_s <= second_s - 4'd1;
            end else begin
               second_s <= BCD_MAX_TENS_S;
               if (first_m != 4'd0) begin
                  first_m <= first_m - 4'd1;
               end else begin
                  first_m  <= BCD_MAX_DIGIT;
                  second_m <= second_m - 4'd1;
               end
            end
         end
      end else if (shift_en) begin
         second_m <= first_m;
         first_m  <= second_s;
         second_s <= first_s;
         first_s  <= shift_digit;
      end
   end

endmodule

// File: rtl/microwave_cook_ctrl.sv
// rtl/microwave_cook_ctrl.sv - cook sequencer: key/door FSM, end-of-cook beep counter, output decode
module microwave_cook_ctrl
   import microwave_pkg::*;
#(
   parameter int unsigned QUICK_START_S = 30,
   parameter int unsigned BEEP_COUNT    = 3
)(
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_1s,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_start,
   input  logic       key_stop,
   input  logic       door_open,
   output logic [3:0] first_s,
   output logic [3:0] second_s,
   output logic [3:0] first_m,
   output logic [3:0] second_m,
   output logic       magnetron_on,
   output logic       lamp_on,
   output logic       buzzer_on,
   output logic [2:0] state
);

   localparam logic [15:0] QUICK_VAL = secs_to_mmss(QUICK_START_S);
   localparam logic [3:0]  BEEP_LAST = 4'(BEEP_COUNT - 1);

   state_t     state_q, state_d;
   logic [3:0] beep_q, beep_d;
   logic       tmr_load, tmr_shift, tmr_dec, tmr_clr;
   logic       tmr_zero, one_left, digit_ok;

   bcd_mmss_down u_timer (
      .clk         (clk),
      .rst         (rst),
      .load        (tmr_load),
      .load_val    (QUICK_VAL),
      .shift_en    (tmr_shift),
      .shift_digit (key_digit),
      .dec_en      (tmr_dec),
      .clr         (tmr_clr),
      .first_s     (first_s),
      .second_s    (second_s),
      .first_m     (first_m),
      .second_m    (second_m),
      .zero        (tmr_zero)
   );

   assign one_left = (second_m == 4'd0) && (first_m == 4'd0) &&
                     (second_s == 4'd0) && (first_s == 4'd1);
   assign digit_ok = key_valid && (key_digit <= BCD_MAX_DIGIT);

   // Each branch takes the highest-priority event that applies in that state.
   always_comb begin
      state_d   = state_q;
      beep_d    = beep_q;
      tmr_load  = 1'b0;
      tmr_shift = 1'b0;
      tmr_dec   = 1'b0;
      tmr_clr   = 1'b0;
      case (state_q)
         S_IDLE, S_SET: begin
            if (key_stop) begin
               tmr_clr = 1'b1;
               state_d = S_IDLE;
            end else if (key_start && !door_open) begin
               tmr_load = tmr_zero;
               state_d  = S_COOK;
            end else if (digit_ok) begin
               tmr_shift = 1'b1;
               state_d   = S_SET;
            end
         end
         S_COOK: begin
            if (door_open || key_stop) begin
               state_d = S_PAUSE;
            end else if (tick_1s) begin
               tmr_dec = 1'b1;
               if (one_left) begin
                  state_d = S_DONE;
                  beep_d  = 4'd0;
               end
            end
         end
         S_PAUSE: begin
            if (key_stop) begin
               tmr_clr = 1'b1;
               state_d = S_IDLE;
            end else if (key_start && !door_open) begin
               state_d = S_COOK;
            end
         end
         S_DONE: begin
            if (door_open || key_stop) begin
               state_d = S_IDLE;
               beep_d  = 4'd0;
            end else if (tick_1s) begin
               if (beep_q == BEEP_LAST) begin
                  state_d = S_IDLE;
                  beep_d  = 4'd0;
               end else begin
                  beep_d = beep_q + 4'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            beep_d  = 4'd0;
            tmr_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         beep_q       <= 4'd0;
         magnetron_on <= 1'b0;
         buzzer_on    <= 1'b0;
      end else begin
         state_q      <= state_d;
         beep_q       <= beep_d;
         magnetron_on <= (state_d == S_COOK);
         buzzer_on    <= (state_d == S_DONE);
      end
   end

   assign lamp_on = magnetron_on | door_open;
   assign state   = state_q;

endmodule

// File: tb/tb_microwave_cook_ctrl.sv
// tb/tb_microwave_cook_ctrl.sv - vector table, directed sequences and randomized model check for microwave_cook_ctrl
module tb_microwave_cook_ctrl;
   import microwave_pkg::*;

   localparam int QUICK = 30;
   localparam int BEEPS = 3;

   logic       clk = 1'b0;
   logic       rst, tick_1s, key_valid, key_start, key_stop, door_open;
   logic [3:0] key_digit;
   logic [3:0] first_s, second_s, first_m, second_m;
   logic       magnetron_on, lamp_on, buzzer_on;
   logic [2:0] state;

   always #5 clk = ~clk;

   microwave_cook_ctrl #(.QUICK_START_S(QUICK), .BEEP_COUNT(BEEPS)) dut (
      .clk(clk), .rst(rst), .tick_1s(tick_1s), .key_valid(key_valid), .key_digit(key_digit),
      .key_start(key_start), .key_stop(key_stop), .door_open(door_open),
      .first_s(first_s), .second_s(second_s), .first_m(first_m), .second_m(second_m),
      .magnetron_on(magnetron_on), .lamp_on(lamp_on), .buzzer_on(buzzer_on), .state(state)
   );

   int nvec = 0;
   int nfail = 0;

   // Reference model: timer held as the decimal number mmss.
   int     m_n;
   int     m_beep;
   state_t m_st;

   typedef struct {
      logic       t, v;
      logic [3:0] d;
      logic       s, p, dr;
      logic [15:0] ed;
      state_t     est;
      logic       emag, ebuz, elamp;
   } vec_t;
   vec_t tbl[$];

   function automatic logic [15:0] mdig(input int n);
      return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic model_reset();
      m_n = 0; m_beep = 0; m_st = S_IDLE;
   endtask

   task automatic model_step(input logic t, v, input logic [3:0] d, input logic s, p, dr);
      case (m_st)
         S_IDLE, S_SET:
            if (p) begin m_n = 0; m_st = S_IDLE; end
            else if (s && !dr) begin if (m_n == 0) m_n = QUICK; m_st = S_COOK; end
            else if (v && d <= 9) begin m_n = (m_n * 10 + int'(d)) % 10000; m_st = S_SET; end
         S_COOK:
            if (dr || p) m_st = S_PAUSE;
            else if (t) begin
               m_n = (m_n % 100 != 0) ? m_n - 1 : m_n - 100 + 59;
               if (m_n == 0) begin m_st = S_DONE; m_beep = 0; end
            end
         S_PAUSE:
            if (p) begin m_n = 0; m_st = S_IDLE; end
            else if (s && !dr) m_st = S_COOK;
         default:
            if (dr || p) begin m_st = S_IDLE; m_beep = 0; end
            else if (t) begin
               m_beep++;
               if (m_beep == BEEPS) begin m_st = S_IDLE; m_beep = 0; end
            end
      endcase
   endtask

   task automatic step(input logic t, v, input logic [3:0] d, input logic s, p, dr);
      tick_1s = t; key_valid = v; key_digit = d; key_start = s; key_stop = p; door_open = dr;
      model_step(t, v, d, s, p, dr);
      @(posedge clk);
      #1;
      tick_1s = 0; key_valid = 0; key_digit = 0; key_start = 0; key_stop = 0;
   endtask

   task automatic chk(input string name, input logic [15:0] ed, input logic [2:0] est,
                      input logic emag, ebuz, elamp);
      logic [15:0] ad;
      ad = {second_m, first_m, second_s, first_s};
      nvec++;
      if (ad !== ed || state !== est || magnetron_on !== emag || buzzer_on !== ebuz || lamp_on !== elamp) begin
         nfail++;
         $display("FAIL %s: got digits=%h state=%0d mag=%b buz=%b lamp=%b, expected digits=%h state=%0d mag=%b buz=%b lamp=%b",
                  name, ad, state, magnetron_on, buzzer_on, lamp_on, ed, est, emag, ebuz, elamp);
      end
   endtask

   task automatic chk_model(input string name);
      chk(name, mdig(m_n), m_st, m_st == S_COOK, m_st == S_DONE, (m_st == S_COOK) || door_open);
   endtask

   task automatic add(input logic t, v, input logic [3:0] d, input logic s, p, dr,
                      input logic [15:0] ed, input state_t est, input logic emag, ebuz, elamp);
      vec_t r;
      r.t = t; r.v = v; r.d = d; r.s = s; r.p = p; r.dr = dr;
      r.ed = ed; r.est = est; r.emag = emag; r.ebuz = ebuz; r.elamp = elamp;
      tbl.push_back(r);
   endtask

   task automatic do_reset();
      rst = 1; tick_1s = 0; key_valid = 0; key_digit = 0; key_start = 0; key_stop = 0; door_open = 0;
      model_reset();
      @(posedge clk);
      #1;
      rst = 0;
   endtask

   task automatic key(input logic [3:0] d);
      step(0, 1, d, 0, 0, 0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) begin
         step(1, 0, 0, 0, 0, 0);
         step(0, 0, 0, 0, 0, 0);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();
      chk("reset", 16'h0000, S_IDLE, 0, 0, 0);
      door_open = 1; #1;
      chk("reset_lamp_door", 16'h0000, S_IDLE, 0, 0, 1);
      door_open = 0; #1;

      // Table: t v d s p dr | digits state mag buz lamp
      add(0,1,4'd1,0,0,0, 16'h0001, S_SET,   0,0,0);
      add(0,1,4'd0,0,0,0, 16'h0010, S_SET,   0,0,0);
      add(0,1,4'd0,0,0,0, 16'h0100, S_SET,   0,0,0);
      add(0,1,4'd0,0,0,0, 16'h1000, S_SET,   0,0,0);
      add(0,0,4'd0,1,0,0, 16'h1000, S_COOK,  1,0,1);
      add(1,0,4'd0,0,0,0, 16'h0959, S_COOK,  1,0,1);
      add(0,1,4'd5,0,0,0, 16'h0959, S_COOK,  1,0,1);
      add(0,0,4'd0,0,1,0, 16'h0959, S_PAUSE, 0,0,0);
      add(1,0,4'd0,0,0,0, 16'h0959, S_PAUSE, 0,0,0);
      add(0,0,4'd0,0,1,0, 16'h0000, S_IDLE,  0,0,0);
      add(0,1,4'd9,0,0,0, 16'h0009, S_SET,   0,0,0);
      add(0,1,4'd0,0,0,0, 16'h0090, S_SET,   0,0,0);
      add(0,1,4'd12,0,0,0,16'h0090, S_SET,   0,0,0);
      add(0,0,4'd0,1,0,1, 16'h0090, S_SET,   0,0,1);
      add(0,0,4'd0,1,0,0, 16'h0090, S_COOK,  1,0,1);
      add(1,0,4'd0,0,0,0, 16'h0089, S_COOK,  1,0,1);
      add(1,0,4'd0,0,1,0, 16'h0089, S_PAUSE, 0,0,0);
      add(0,0,4'd0,0,1,0, 16'h0000, S_IDLE,  0,0,0);
      add(0,1,4'd9,0,0,0, 16'h0009, S_SET,   0,0,0);
      add(0,1,4'd9,0,0,0, 16'h0099, S_SET,   0,0,0);
      add(0,1,4'd9,0,0,0, 16'h0999, S_SET,   0,0,0);
      add(0,1,4'd9,0,0,0, 16'h9999, S_SET,   0,0,0);
      add(0,1,4'd9,0,0,0, 16'h9999, S_SET,   0,0,0);
      add(0,0,4'd0,0,1,0, 16'h0000, S_IDLE,  0,0,0);
      add(0,0,4'd0,0,1,0, 16'h0000, S_IDLE,  0,0,0);
      add(0,0,4'd0,1,1,0, 16'h0000, S_IDLE,  0,0,0);
      add(0,0,4'd0,1,0,0, 16'h0030, S_COOK,  1,0,1);
      add(1,0,4'd0,0,0,1, 16'h0030, S_PAUSE, 0,0,1);
      add(0,0,4'd0,1,0,1, 16'h0030, S_PAUSE, 0,0,1);
      add(0,0,4'd0,0,0,0, 16'h0030, S_PAUSE, 0,0,0);
      add(0,0,4'd0,0,1,0, 16'h0000, S_IDLE,  0,0,0);
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].t, tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].p, tbl[i].dr);
         chk($sformatf("vec%0d", i), tbl[i].ed, tbl[i].est, tbl[i].emag, tbl[i].ebuz, tbl[i].elamp);
      end

      // Full cook of 01:23 with end-of-cook beeps
      do_reset();
      key(4'd1); key(4'd2); key(4'd3);
      chk("entry_0123", 16'h0123, S_SET, 0, 0, 0);
      step(0, 0, 0, 1, 0, 0);
      chk("start_0123", 16'h0123, S_COOK, 1, 0, 1);
      ticks(82);
      chk("cook_0001", 16'h0001, S_COOK, 1, 0, 1);
      ticks(1);
      chk("cook_done", 16'h0000, S_DONE, 0, 1, 0);
      ticks(1);
      chk("beep1", 16'h0000, S_DONE, 0, 1, 0);
      ticks(1);
      chk("beep2", 16'h0000, S_DONE, 0, 1, 0);
      ticks(1);
      chk("beep_end", 16'h0000, S_IDLE, 0, 0, 0);

      // Quick start, then door opened during the beeps
      step(0, 0, 0, 1, 0, 0);
      chk("quick_start", 16'h0030, S_COOK, 1, 0, 1);
      ticks(29);
      chk("quick_0001", 16'h0001, S_COOK, 1, 0, 1);
      ticks(1);
      chk("quick_done", 16'h0000, S_DONE, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("door_in_done", 16'h0000, S_IDLE, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // Door pause and resume from 00:10
      key(4'd1); key(4'd0);
      step(0, 0, 0, 1, 0, 0);
      ticks(4);
      chk("door_pre", 16'h0006, S_COOK, 1, 0, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("door_pause", 16'h0006, S_PAUSE, 0, 0, 1);
      step(0, 0, 0, 1, 0, 0);
      chk("resume", 16'h0006, S_COOK, 1, 0, 1);
      ticks(5);
      chk("resume_0001", 16'h0001, S_COOK, 1, 0, 1);
      ticks(1);
      chk("resume_done", 16'h0000, S_DONE, 0, 1, 0);
      ticks(3);
      chk("resume_idle", 16'h0000, S_IDLE, 0, 0, 0);

      // Stop coincident with tick at 00:05
      key(4'd5);
      step(0, 0, 0, 1, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      chk("stop_tick", 16'h0005, S_PAUSE, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("stop_clear", 16'h0000, S_IDLE, 0, 0, 0);

      // Asynchronous reset mid-cook
      key(4'd2); key(4'd0); key(4'd0);
      step(0, 0, 0, 1, 0, 0);
      chk("cook_0200", 16'h0200, S_COOK, 1, 0, 1);
      #2 rst = 1;
      #1 chk("async_rst", 16'h0000, S_IDLE, 0, 0, 0);
      model_reset();
      @(posedge clk);
      #1 rst = 0;

      // Randomized run against the model
      for (int i = 0; i < 3000; i++) begin
         logic t, v, s, p, dr;
         logic [3:0] d;
         dr = door_open;
         if ($urandom_range(0, 59) == 0) dr = ~dr;
         t = ($urandom_range(0, 2) == 0);
         v = ($urandom_range(0, 5) == 0);
         d = 4'($urandom_range(0, 15));
         s = ($urandom_range(0, 9) == 0);
         p = ($urandom_range(0, 59) == 0);
         step(t, v, d, s, p, dr);
         chk_model($sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule
